// File: rtl/move_tick_sequencer.sv
// Elevator motion timebase: move_tick every MOVE_TIME cycles in RUN, door dwell, resumable pause.
// Define MOVE_CLK_OUT_EN to add the legacy move_clk square-wave output.
module move_tick_sequencer #(
  parameter int FLOORS     = 3,
  parameter int MOVE_TIME  = 10,
  parameter int DWELL_TIME = 20,
  parameter int CNT_W      = 26
) (
  input  logic                        clk,
  input  logic                        button_reset_n,
  input  logic [FLOORS-1:0]           floor_leds,
  input  logic                        move_handler,
  input  logic                        sos_mode,
  input  logic                        weight_limit_exceeded,
  output logic                        move_tick,
  output logic [1:0]                  state,
  output logic [$clog2(FLOORS)-1:0]   floor_idx,
  output logic                        floor_err
`ifdef MOVE_CLK_OUT_EN
  ,
  output logic                        move_clk
`endif
);

  localparam int IDX_W  = $clog2(FLOORS);
  localparam int ONES_W = $clog2(FLOORS + 1);
  localparam logic [CNT_W-1:0] MT_LAST = CNT_W'(MOVE_TIME - 1);
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL_TIME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DWELL = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t             r_state, w_state_nx;
  state_t             r_resume, w_resume_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_tick, w_tick_nx;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic               r_err;
  logic               r_atq;
  logic [ONES_W-1:0]  w_ones;
  logic               w_at, w_hold, w_arrival;
  logic               w_one, w_multi;

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (floor_leds[i]) begin
        w_ones = w_ones + ONES_W'(1);
        w_idx  = IDX_W'(i);
      end
    end
  end

  assign w_one     = (w_ones == ONES_W'(1));
  assign w_multi   = (w_ones > ONES_W'(1));
  assign w_at      = |floor_leds;
  assign w_hold    = sos_mode | weight_limit_exceeded | r_err;
  assign w_arrival = w_at & ~r_atq;

  always_comb begin
    w_state_nx  = r_state;
    w_resume_nx = r_resume;
    w_cnt_nx    = r_cnt;
    w_tick_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (move_handler & ~w_hold)
          w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (w_hold) begin
          w_state_nx  = S_PAUSE;
          w_resume_nx = S_RUN;
        end else if (w_arrival) begin
          w_state_nx = S_DWELL;
          w_cnt_nx   = '0;
        end else if (~move_handler & w_at) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == MT_LAST) begin
          w_cnt_nx  = '0;
          w_tick_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (w_hold) begin
          w_state_nx  = S_PAUSE;
          w_resume_nx = S_DWELL;
        end else if (r_cnt == DW_LAST) begin
          w_state_nx = move_handler ? S_RUN : S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (~w_hold)
          w_state_nx = r_resume;
      end
    endcase
  end

  always_ff @(posedge clk or negedge button_reset_n) begin
    if (!button_reset_n) begin
      r_state  <= S_IDLE;
      r_resume <= S_RUN;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_atq    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_resume <= w_resume_nx;
      r_cnt    <= w_cnt_nx;
      r_tick   <= w_tick_nx;
      r_err    <= w_multi;
      r_atq    <= w_at;
      if (w_one)
        r_idx <= w_idx;
    end
  end

`ifdef MOVE_CLK_OUT_EN
  logic r_mclk;

  // Toggles on the same edge that raises move_tick.
  always_ff @(posedge clk or negedge button_reset_n) begin
    if (!button_reset_n)
      r_mclk <= 1'b0;
    else if (w_tick_nx)
      r_mclk <= ~r_mclk;
  end

  assign move_clk = r_mclk;
`endif

  assign move_tick = r_tick;
  assign state     = r_state;
  assign floor_idx = r_idx;
  assign floor_err = r_err;

endmodule

// File: tb/tb_move_tick_sequencer.sv
// Self-checking bench for move_tick_sequencer: cycle-level reference model
// plus directed scenarios with hand-computed timing expectations.
module tb_move_tick_sequencer;

  localparam int MT = 10;
  localparam int DW = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] leds = 3'b000;
  logic       mh = 1'b0;
  logic       sos = 1'b0;
  logic       wt = 1'b0;
  logic       move_tick;
  logic [1:0] state;
  logic [1:0] floor_idx;
  logic       floor_err;
  logic       move_clk;

  int vectors = 0;
  int fails = 0;

  move_tick_sequencer #(
    .FLOORS(3), .MOVE_TIME(MT), .DWELL_TIME(DW), .CNT_W(26)
  ) dut (
    .clk(clk),
    .button_reset_n(rst_n),
    .floor_leds(leds),
    .move_handler(mh),
    .sos_mode(sos),
    .weight_limit_exceeded(wt),
    .move_tick(move_tick),
    .state(state),
    .floor_idx(floor_idx),
    .floor_err(floor_err)
`ifdef MOVE_CLK_OUT_EN
    ,
    .move_clk(move_clk)
`endif
  );

`ifndef MOVE_CLK_OUT_EN
  assign move_clk = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks elapsed run/dwell time and derives ticks by modulo.
  int m_st = 0, m_res = 1, m_run = 0, m_dw = 0;
  int m_tick = 0, m_idx = 0, m_err = 0, m_atq = 0, m_mclk = 0;

  always @(posedge clk or negedge rst_n) begin
    int ns, nt;
    bit at, hold, arr;
    if (!rst_n) begin
      m_st = 0; m_res = 1; m_run = 0; m_dw = 0;
      m_tick = 0; m_idx = 0; m_err = 0; m_atq = 0; m_mclk = 0;
    end else begin
      at   = |leds;
      hold = sos || wt || (m_err != 0);
      arr  = at && (m_atq == 0);
      nt   = 0;
      ns   = m_st;
      case (m_st)
        0: if (mh && !hold) begin ns = 1; m_run = 0; end
        1: begin
          if (hold) begin ns = 3; m_res = 1; end
          else if (arr) begin ns = 2; m_dw = 0; end
          else if (!mh && at) ns = 0;
          else begin
            m_run++;
            nt = (m_run % MT == 0) ? 1 : 0;
          end
        end
        2: begin
          if (hold) begin ns = 3; m_res = 2; end
          else begin
            m_dw++;
            if (m_dw == DW) begin ns = mh ? 1 : 0; m_run = 0; end
          end
        end
        default: if (!hold) ns = m_res;
      endcase
      m_st   = ns;
      m_tick = nt;
      m_mclk = m_mclk ^ nt;
      m_err  = ($countones(leds) > 1) ? 1 : 0;
      if ($countones(leds) == 1) m_idx = $clog2(leds);
      m_atq  = at ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("state", int'(state), m_st);
      chk("move_tick", int'(move_tick), m_tick);
      chk("floor_idx", int'(floor_idx), m_idx);
      chk("floor_err", int'(floor_err), m_err);
`ifdef MOVE_CLK_OUT_EN
      chk("move_clk", int'(move_clk), m_mclk);
`endif
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move_tick && n < 200);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(move_tick), 0);
    chk("rst_idx", int'(floor_idx), 0);
    chk("rst_err", int'(floor_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Free run between floors
    mh = 1'b1;
    @(negedge clk);
    chk("run_entry", int'(state), 1);
    wait_tick(n);
    chk("first_tick_latency", n, MT);
    wait_tick(n);
    chk("tick_period", n, MT);
    @(negedge clk);
    chk("tick_width", int'(move_tick), 0);
    wait_tick(n);

    // SOS pause at counter 6, resume keeps the count
    repeat (6) @(negedge clk);
    sos = 1'b1;
    @(negedge clk);
    chk("sos_pause", int'(state), 3);
    repeat (49) @(negedge clk);
    sos = 1'b0;
    @(negedge clk);
    chk("sos_resume", int'(state), 1);
    wait_tick(n);
    chk("tick_after_resume", n, 4);

    // Arrival with no further request -> dwell -> idle
    leds = 3'b010;
    mh = 1'b0;
    @(negedge clk);
    chk("dwell_entry", int'(state), 2);
    chk("dwell_idx", int'(floor_idx), 1);
    n = 0;
    while (state == 2'd2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("dwell_len", n, DW);
    chk("dwell_to_idle", int'(state), 0);

    // Depart from floor, then two-bit sensor fault
    mh = 1'b1;
    @(negedge clk);
    chk("run_from_floor", int'(state), 1);
    repeat (3) @(negedge clk);
    leds = 3'b011;
    @(negedge clk);
    chk("err_set", int'(floor_err), 1);
    chk("err_still_run", int'(state), 1);
    @(negedge clk);
    chk("err_pause", int'(state), 3);
    chk("err_idx_held", int'(floor_idx), 1);
    repeat (3) @(negedge clk);
    leds = 3'b010;
    @(negedge clk);
    chk("err_clear", int'(floor_err), 0);
    chk("err_still_pause", int'(state), 3);
    @(negedge clk);
    chk("err_resume", int'(state), 1);
    wait_tick(n);
    chk("tick_after_fault", (n <= MT) ? 1 : 0, 1);

    // Leave floor, arrive at floor 2, overweight during dwell
    leds = 3'b000;
    repeat (4) @(negedge clk);
    leds = 3'b100;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state == 2'd2) n++;
      if (state == 2'd1) break;
      if (i == 5) wt = 1'b1;
      if (i == 10) chk("wt_pause", int'(state), 3);
      if (i == 15) wt = 1'b0;
    end
    chk("dwell_with_pause", n, DW + 1);
    chk("dwell_to_run", int'(state), 1);
    chk("idx_floor2", int'(floor_idx), 2);

    // Asynchronous reset mid-period
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_tick", int'(move_tick), 0);
    chk("arst_idx", int'(floor_idx), 0);
    chk("arst_err", int'(floor_err), 0);
    @(negedge clk);
    mh = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mh = 1'b1;
    repeat (15) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
